// File: rtl/phys_reg_free_list.sv
// Purpose : circular free list of physical register tags between rename/dispatch
//           and ROB commit. It hands out up to 2 tags per cycle and reclaims up to
//           2 superseded tags per cycle. On a mispredict, head rewinds to a snapshot.
// Latency : alloc_tag_1/2, allocatable and free_count are combinational from state;
//           allocations and releases take effect on the next clock edge.
// Backpressure: allocatable drops when free_count < reqnum, and head then holds.
//           Dispatch must stall itself. Releases are never refused, but releases
//           past full are dropped and set the sticky overflow flag.
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   invalid1/2, stall_DP   dispatch request shape and stall
//   alloc_tag_1/2          tags at head / head+1
//   allocatable            free_count >= reqnum
//   fl_head, free_count    head pointer (with wrap bit) and occupancy
//   prmiss, prmiss_fl_head mispredict rewind of head
//   commit_*               commit-side releases of previous mappings
//   overflow               sticky: release attempted into a full list
module phys_reg_free_list #(
  parameter int PHY_REG_NUM  = 64,
  parameter int PHY_REG_SEL  = 6,
  parameter int ARCH_REG_NUM = 32,
  parameter int REG_SEL      = 5,
  parameter int FL_NUM       = PHY_REG_NUM - ARCH_REG_NUM,
  parameter int FL_SEL       = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   invalid1,
  input  logic                   invalid2,
  input  logic                   stall_DP,
  output logic [PHY_REG_SEL-1:0] alloc_tag_1,
  output logic [PHY_REG_SEL-1:0] alloc_tag_2,
  output logic                   allocatable,
  output logic [FL_SEL:0]        fl_head,
  output logic [FL_SEL:0]        free_count,
  input  logic                   prmiss,
  input  logic [FL_SEL:0]        prmiss_fl_head,
  input  logic                   commit_valid1,
  input  logic                   commit_valid2,
  input  logic [REG_SEL-1:0]     commit_dst_1,
  input  logic [REG_SEL-1:0]     commit_dst_2,
  input  logic [PHY_REG_SEL-1:0] commit_release_tag_1,
  input  logic [PHY_REG_SEL-1:0] commit_release_tag_2,
  output logic                   overflow
);

  localparam int PTR_W = FL_SEL + 1;
  // Wide enough to hold free_count + 2 without wrapping.
  localparam int CNT_W = FL_SEL + 3;

  logic [PHY_REG_SEL-1:0] entry_q [FL_NUM];
  logic [PHY_REG_SEL-1:0] entry_d [FL_NUM];
  logic [PTR_W-1:0]       head_q, head_d;
  logic [PTR_W-1:0]       tail_q, tail_d;
  logic                   overflow_q, overflow_d;

  logic [1:0]             reqnum;
  logic                   alloc_fire;
  logic [1:0]             alloc_num;
  logic                   rel1, rel2;
  logic [1:0]             rel_num;
  logic [CNT_W-1:0]       fill_after;
  logic [CNT_W-1:0]       room;
  logic [1:0]             accept_num;
  logic [PHY_REG_SEL-1:0] first_tag;
  logic [FL_SEL-1:0]      head_idx, head_idx1;
  logic [FL_SEL-1:0]      tail_idx, tail_idx1;

  // Index arithmetic wraps naturally because FL_NUM is a power of two.
  assign head_idx  = head_q[FL_SEL-1:0];
  assign head_idx1 = head_idx + 1'b1;
  assign tail_idx  = tail_q[FL_SEL-1:0];
  assign tail_idx1 = tail_idx + 1'b1;

  // The wrap bit separates full (tail - head = FL_NUM) from empty (0).
  assign free_count  = tail_q - head_q;
  assign fl_head     = head_q;
  assign alloc_tag_1 = entry_q[head_idx];
  assign alloc_tag_2 = entry_q[head_idx1];
  assign overflow    = overflow_q;

  // Slot 2 alone is not a request: dispatch always fills slot 1 first.
  always_comb begin
    reqnum = 2'd0;
    if (!invalid1 && !invalid2) begin
      reqnum = 2'd2;
    end else if (!invalid1) begin
      reqnum = 2'd1;
    end
  end

  // Same-cycle releases are deliberately not counted toward allocatable.
  assign allocatable = (free_count >= PTR_W'(reqnum));
  assign alloc_fire  = !stall_DP && !prmiss && allocatable;
  assign alloc_num   = alloc_fire ? reqnum : 2'd0;

  // A zero architectural destination writes no register, so nothing is freed.
  assign rel1    = commit_valid1 && (commit_dst_1 != '0);
  assign rel2    = commit_valid2 && (commit_dst_2 != '0);
  assign rel_num = {1'b0, rel1} + {1'b0, rel2};

  // Occupancy after this cycle's allocation and releases, checked against capacity.
  // free_count >= alloc_num whenever alloc fires, so there is no underflow.
  assign fill_after = CNT_W'(free_count) - CNT_W'(alloc_num) + CNT_W'(rel_num);
  assign room       = CNT_W'(FL_NUM) - (CNT_W'(free_count) - CNT_W'(alloc_num));

  // Releases beyond the free space are dropped so live entries are never clobbered.
  always_comb begin
    accept_num = rel_num;
    if (CNT_W'(rel_num) > room) begin
      accept_num = room[1:0];
    end
  end

  // Release slot order is preserved: slot 1's tag goes first when both are valid.
  assign first_tag = rel1 ? commit_release_tag_1 : commit_release_tag_2;

  always_comb begin
    entry_d    = entry_q;
    head_d     = head_q;
    tail_d     = tail_q;
    overflow_d = overflow_q;

    if (reset) begin
      for (int i = 0; i < FL_NUM; i++) begin
        entry_d[i] = PHY_REG_SEL'(ARCH_REG_NUM + i);
      end
      head_d     = '0;
      tail_d     = PTR_W'(FL_NUM);
      overflow_d = 1'b0;
    end else begin
      // Commits are older than any mispredict, so releases always apply.
      if (accept_num != 2'd0) begin
        entry_d[tail_idx] = first_tag;
      end
      if (accept_num == 2'd2) begin
        entry_d[tail_idx1] = commit_release_tag_2;
      end
      tail_d = tail_q + PTR_W'(accept_num);

      // A rewind returns every wrong-path allocation made after the snapshot.
      if (prmiss) begin
        head_d = prmiss_fl_head;
      end else begin
        head_d = head_q + PTR_W'(alloc_num);
      end

      if (fill_after > CNT_W'(FL_NUM)) begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    entry_q    <= entry_d;
    head_q     <= head_d;
    tail_q     <= tail_d;
    overflow_q <= overflow_d;
  end

endmodule

// File: tb/tb_phys_reg_free_list.sv
module tb_phys_reg_free_list;

  logic       clk = 1'b0;
  logic       reset;
  logic       invalid1, invalid2, stall_DP;
  logic [5:0] alloc_tag_1, alloc_tag_2;
  logic       allocatable;
  logic [5:0] fl_head, free_count;
  logic       prmiss;
  logic [5:0] prmiss_fl_head;
  logic       commit_valid1, commit_valid2;
  logic [4:0] commit_dst_1, commit_dst_2;
  logic [5:0] commit_release_tag_1, commit_release_tag_2;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  // Reference model: an unbounded count of tags ever handed out (m_head) and
  // ever returned (m_tail), plus a 32-slot ring of tag values.
  int         m_head, m_tail;
  logic [5:0] m_mem [32];
  bit         m_ovf;
  int         pm_target;
  int         snap;
  bit         snap_valid;

  always #5 clk = ~clk;

  phys_reg_free_list dut (
    .clk                  (clk),
    .reset                (reset),
    .invalid1             (invalid1),
    .invalid2             (invalid2),
    .stall_DP             (stall_DP),
    .alloc_tag_1          (alloc_tag_1),
    .alloc_tag_2          (alloc_tag_2),
    .allocatable          (allocatable),
    .fl_head              (fl_head),
    .free_count           (free_count),
    .prmiss               (prmiss),
    .prmiss_fl_head       (prmiss_fl_head),
    .commit_valid1        (commit_valid1),
    .commit_valid2        (commit_valid2),
    .commit_dst_1         (commit_dst_1),
    .commit_dst_2         (commit_dst_2),
    .commit_release_tag_1 (commit_release_tag_1),
    .commit_release_tag_2 (commit_release_tag_2),
    .overflow             (overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_mem[i] = 6'(32 + i);
    m_head     = 0;
    m_tail     = 32;
    m_ovf      = 0;
    snap_valid = 0;
  endtask

  function automatic int cur_req();
    if (!invalid1 && !invalid2) return 2;
    if (!invalid1) return 1;
    return 0;
  endfunction

  task automatic check_model();
    int fc;
    int req;
    fc  = m_tail - m_head;
    req = cur_req();
    chk("free_count", free_count, 32'(fc % 64));
    chk("fl_head", fl_head, 32'(m_head % 64));
    chk("allocatable", allocatable, 32'(fc >= req));
    chk("overflow", overflow, 32'(m_ovf));
    if (req >= 1 && fc >= 1) chk("alloc_tag_1", alloc_tag_1, 32'(m_mem[m_head % 32]));
    if (req == 2 && fc >= 2) chk("alloc_tag_2", alloc_tag_2, 32'(m_mem[(m_head + 1) % 32]));
  endtask

  task automatic model_advance();
    int fc, req, alloc, n, room, acc;
    logic [5:0] tv [2];
    if (reset) begin
      model_reset();
      return;
    end
    fc    = m_tail - m_head;
    req   = cur_req();
    alloc = (!stall_DP && !prmiss && fc >= req) ? req : 0;
    n = 0;
    if (commit_valid1 && commit_dst_1 != 0) begin tv[n] = commit_release_tag_1; n++; end
    if (commit_valid2 && commit_dst_2 != 0) begin tv[n] = commit_release_tag_2; n++; end
    if (fc - alloc + n > 32) m_ovf = 1;
    room = 32 - (fc - alloc);
    acc  = (n < room) ? n : room;
    for (int k = 0; k < acc; k++) m_mem[(m_tail + k) % 32] = tv[k];
    m_tail = m_tail + acc;
    m_head = prmiss ? pm_target : m_head + alloc;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic commit_cycle();
    check_model();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    at_neg();
    commit_cycle();
  endtask

  task automatic idle_inputs();
    invalid1 = 1; invalid2 = 1; stall_DP = 0; prmiss = 0; prmiss_fl_head = 0;
    commit_valid1 = 0; commit_valid2 = 0; commit_dst_1 = 0; commit_dst_2 = 0;
    commit_release_tag_1 = 0; commit_release_tag_2 = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    step();
    reset = 0;
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    reset = 0;

    // Reset state
    at_neg();
    chk("rst_free_count", free_count, 32);
    chk("rst_fl_head", fl_head, 0);
    chk("rst_allocatable", allocatable, 1);
    chk("rst_overflow", overflow, 0);
    commit_cycle();

    // Drain the list two tags at a time
    invalid1 = 0; invalid2 = 0;
    for (int i = 0; i < 16; i++) begin
      at_neg();
      chk("drain_tag1", alloc_tag_1, 32'(32 + 2 * i));
      chk("drain_tag2", alloc_tag_2, 32'(33 + 2 * i));
      commit_cycle();
    end
    at_neg();
    chk("empty_free_count", free_count, 0);
    chk("empty_allocatable", allocatable, 0);
    chk("empty_head_wrap", fl_head, 32);
    commit_cycle();

    // Release from empty with a same-cycle request: no bypass
    invalid1 = 0; invalid2 = 1;
    commit_valid1 = 1; commit_dst_1 = 3; commit_release_tag_1 = 5;
    at_neg();
    chk("nobypass_allocatable", allocatable, 0);
    commit_cycle();
    idle_inputs();
    invalid1 = 0; stall_DP = 1;
    at_neg();
    chk("after_rel_free_count", free_count, 1);
    chk("after_rel_allocatable", allocatable, 1);
    chk("after_rel_tag1", alloc_tag_1, 5);
    commit_cycle();

    // Zero destination in slot 1 releases nothing; slot 2 goes to tail
    idle_inputs();
    commit_valid1 = 1; commit_dst_1 = 0; commit_release_tag_1 = 17;
    commit_valid2 = 1; commit_dst_2 = 7; commit_release_tag_2 = 9;
    step();
    idle_inputs();
    invalid1 = 0; invalid2 = 0; stall_DP = 1;
    at_neg();
    chk("dst0_free_count", free_count, 2);
    chk("dst0_tag1", alloc_tag_1, 5);
    chk("dst0_tag2", alloc_tag_2, 9);
    commit_cycle();

    // Mispredict rewind with same-cycle release
    do_reset();
    invalid1 = 0; invalid2 = 0;
    step();
    at_neg();
    chk("snap_head", fl_head, 2);
    commit_cycle();
    step();
    invalid1 = 0; invalid2 = 0;
    prmiss = 1; prmiss_fl_head = 2; pm_target = 2;
    commit_valid1 = 1; commit_dst_1 = 1; commit_release_tag_1 = 40;
    step();
    idle_inputs();
    invalid1 = 0;
    at_neg();
    chk("prmiss_head", fl_head, 2);
    chk("prmiss_free_count", free_count, 31);
    chk("prmiss_tag1", alloc_tag_1, 34);
    commit_cycle();

    // Stall holds head
    do_reset();
    invalid1 = 0; invalid2 = 0; stall_DP = 1;
    for (int i = 0; i < 3; i++) begin
      at_neg();
      chk("stall_head", fl_head, 0);
      chk("stall_tag1", alloc_tag_1, 32);
      chk("stall_tag2", alloc_tag_2, 33);
      commit_cycle();
    end

    // Release into a full list
    do_reset();
    commit_valid1 = 1; commit_dst_1 = 1; commit_release_tag_1 = 10;
    step();
    idle_inputs();
    at_neg();
    chk("ovf_set", overflow, 1);
    chk("ovf_free_count", free_count, 32);
    commit_cycle();
    repeat (3) step();
    at_neg();
    chk("ovf_sticky", overflow, 1);
    commit_cycle();
    do_reset();
    at_neg();
    chk("ovf_cleared", overflow, 0);
    commit_cycle();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      idle_inputs();
      invalid1 = ($urandom_range(0, 3) == 0);
      invalid2 = ($urandom_range(0, 3) == 0);
      stall_DP = ($urandom_range(0, 3) == 0);
      commit_valid1 = $urandom_range(0, 1) == 1;
      commit_valid2 = $urandom_range(0, 1) == 1;
      commit_dst_1 = 5'($urandom_range(0, 31));
      commit_dst_2 = 5'($urandom_range(0, 31));
      commit_release_tag_1 = 6'($urandom_range(0, 63));
      commit_release_tag_2 = 6'($urandom_range(0, 63));
      if (snap_valid && (m_tail - snap > 30)) snap_valid = 0;
      if (!snap_valid && $urandom_range(0, 9) == 0) begin
        snap = m_head;
        snap_valid = 1;
      end else if (snap_valid && m_head > snap && $urandom_range(0, 7) == 0) begin
        prmiss = 1;
        pm_target = snap;
        prmiss_fl_head = 6'(snap % 64);
        snap_valid = 0;
      end
      reset = ($urandom_range(0, 299) == 0);
      step();
      reset = 0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/phys_reg_free_list.md
Name: phys_reg_free_list

Overview:
Circular free list of physical register tags, sitting between rename/dispatch and ROB commit. It supplies up to 2 free tags per cycle to dispatch, and reclaims up to 2 superseded tags per cycle from the commit outputs (commit_release_tag_*). On a branch mispredict it rewinds its read pointer to a head snapshot taken at rename, which returns the wrong-path allocations to the list.

Parameters:
PHY_REG_NUM, 64, total physical registers
PHY_REG_SEL, 6, physical tag width
ARCH_REG_NUM, 32, architectural registers; phys 0..ARCH_REG_NUM-1 are mapped at reset
REG_SEL, 5, architectural register index width
FL_NUM, PHY_REG_NUM-ARCH_REG_NUM (32), free list depth
FL_SEL, 5, log2(FL_NUM)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
invalid1  in  1  dispatch slot 1 carries no instruction
invalid2  in  1  dispatch slot 2 carries no instruction
stall_DP  in  1  dispatch stalled; no allocation this cycle
alloc_tag_1  out  PHY_REG_SEL  tag for slot 1
alloc_tag_2  out  PHY_REG_SEL  tag for slot 2
allocatable  out  1  enough free tags for the current request
fl_head  out  FL_SEL+1  current head pointer with wrap bit; rename snapshots it per branch
free_count  out  FL_SEL+1  number of free tags
prmiss  in  1  branch mispredict recovery
prmiss_fl_head  in  FL_SEL+1  head snapshot to restore
commit_valid1  in  1  commit slot 1 valid
commit_valid2  in  1  commit slot 2 valid
commit_dst_1  in  REG_SEL  architectural destination of commit slot 1
commit_dst_2  in  REG_SEL  architectural destination of commit slot 2
commit_release_tag_1  in  PHY_REG_SEL  previous mapping freed by commit slot 1
commit_release_tag_2  in  PHY_REG_SEL  previous mapping freed by commit slot 2
overflow  out  1  sticky error: release into a full list

Behaviour:
- Storage: entry[FL_NUM] of PHY_REG_SEL bits. head and tail are each FL_SEL+1 bits; the MSB is the wrap bit. Index = low FL_SEL bits. free_count = tail - head, modulo 2^(FL_SEL+1).
- Reset: entry[i] = ARCH_REG_NUM + i; head = 0; tail = FL_NUM (wrap bit 1, index 0); free_count = FL_NUM; overflow = 0; allocatable = 1 (combinational).
- reqnum = 2 if ~invalid1 & ~invalid2; 1 if ~invalid1 only; else 0. Slot 2 without slot 1 counts as 0.
- alloc_tag_1 = entry[head]; alloc_tag_2 = entry[head+1]. Both are combinational and valid whenever free_count covers the request.
- allocatable = (free_count >= reqnum). Same-cycle releases are not counted; there is no bypass.
- Allocation fires when ~stall_DP & ~prmiss & allocatable; head += reqnum. If ~stall_DP & ~allocatable, head holds. Dispatch must itself stall on ~allocatable.
- Release conditions: r1 = commit_valid1 & (commit_dst_1 != 0); r2 = commit_valid2 & (commit_dst_2 != 0). A zero destination means no register write, so nothing is released.
- Release writes:
  - r1 & r2: entry[tail] = tag_1, entry[tail+1] = tag_2.
  - r2 only: entry[tail] = tag_2.
  - tail += r1 + r2.
- Releases are applied every cycle regardless of stall_DP or prmiss, because committed instructions are older than any mispredict.
- prmiss: head <= prmiss_fl_head; no allocation that cycle; tail still advances by the releases.
- Next-cycle free_count = new tail - new head.
- overflow: set if (free_count - allocated_this_cycle + r1 + r2) > FL_NUM. Cleared only by reset. Entries are not written past full.
- Wrap-around: the index wraps mod FL_NUM and the wrap bit toggles. Full (free_count = FL_NUM) and empty (free_count = 0) are distinguished solely by the wrap bit.
- Reset mid-operation: all state returns to reset values on the next edge; pending requests and releases are dropped.

Test Plan:
- Reset, reqnum=2 with no stall, 16 cycles -> tags 32,33 / 34,35 / ... / 62,63; then free_count=0, allocatable=0 for reqnum>=1, head wrap bit=1.
- From empty: commit_valid1=1, dst_1=3, release_tag=5, same-cycle reqnum=1 -> no allocation that cycle, allocatable=0; next cycle free_count=1, allocatable=1, alloc_tag_1=5.
- commit_valid1=1 with dst_1=0, commit_valid2=1 with dst_2=7, release_tag_2=9 -> only tag 9 written at tail; tail advances by 1.
- Allocate 6 tags, snapshot fl_head=2 after the first, then prmiss with prmiss_fl_head=2 plus same-cycle release of tag 40 -> head=2, free_count=FL_NUM-2+1=31, alloc_tag_1=34.
- stall_DP=1 with reqnum=2 for 3 cycles -> head unchanged, alloc_tag_1/2 stable at 32/33.
- At full (reset state), release tag 10 -> overflow=1 next cycle and stays 1 until reset; free_count remains 32.
